// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side transmitter. Queues scancode bytes and serialises
// each one as an 11-bit frame (start, d0..d7, odd parity, stop), LSB first, on
// a divided-down PS/2 clock/data pair.
//
// Build option: define PS2TX_FIFO_EN for a 2**AW-entry circular FIFO.
// Leave it undefined for a single holding register (AW then only sizes the
// occupancy count, whose upper bits stay constant zero).
//
// Ports:
//   clock  - system clock, rising edge
//   power  - asynchronous active-low reset
//   data   - scancode byte to enqueue
//   write  - one-cycle enqueue strobe, accepted only while full is low
//   full   - queue cannot accept a byte (registered)
//   busy   - frame or inter-frame gap in progress, or queue non-empty (registered)
//   ps2Ck  - PS/2 clock, idles high (registered)
//   ps2D   - PS/2 data, idles high (registered)
module ps2_kbd_tx #(
   parameter int unsigned CLKDIV = 1418,
   parameter int unsigned AW     = 3
) (
   input  logic       clock,
   input  logic       power,
   input  logic [7:0] data,
   input  logic       write,
   output logic       full,
   output logic       busy,
   output logic       ps2Ck,
   output logic       ps2D
);

   localparam int unsigned HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int unsigned CW = AW + 1;
`ifdef PS2TX_FIFO_EN
   localparam int unsigned CAP = 2 ** AW;
`else
   localparam int unsigned CAP = 1;
`endif
   localparam logic [HW-1:0] HMAX  = HW'(CLKDIV - 1);
   localparam logic [CW-1:0] CAP_C = CW'(CAP);
   localparam logic [3:0]    LAST  = 4'd10;

   typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

   state_t        state, state_nxt;
   logic [HW-1:0] hcnt, hcnt_nxt;
   logic [3:0]    bitcnt, bitcnt_nxt;
   logic          gap2, gap2_nxt;
   logic [9:0]    shift, shift_nxt;
   logic          ck_nxt, d_nxt;
   logic          hdone;

   logic          pop;
   logic          push;
   logic          q_empty;
   logic [7:0]    q_head;
   logic [CW-1:0] count, count_nxt;
   logic          full_nxt, busy_nxt;

   // Writes are gated by the registered full flag only, so a write in the
   // cycle that frees the last slot is still dropped.
   assign push    = write & ~full;
   assign q_empty = (count == '0);

   // Occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clock or negedge power) begin
      if (!power) count <= '0;
      else        count <= count_nxt;
   end

`ifdef PS2TX_FIFO_EN
   // Circular FIFO storage; pointers wrap modulo 2**AW.
   logic [7:0]    mem [CAP];
   logic [AW-1:0] rptr, wptr;

   assign q_head = mem[rptr];

   always_ff @(posedge clock or negedge power) begin
      if (!power) begin
         rptr <= '0;
         wptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wptr] <= data;
   end
`else
   // Single holding register; occupancy is count[0].
   logic [7:0] hold;

   assign q_head = hold;

   always_ff @(posedge clock or negedge power) begin
      if (!power)    hold <= '0;
      else if (push) hold <= data;
   end
`endif

   assign hdone = (hcnt == HMAX);

   // Frame FSM: IDLE -> (HIGH -> LOW) x 11 -> GAP (two half-periods) -> IDLE.
   // shift holds the bits still to be sent after the start bit.
   always_comb begin
      state_nxt  = state;
      hcnt_nxt   = hcnt + 1'b1;
      bitcnt_nxt = bitcnt;
      gap2_nxt   = gap2;
      shift_nxt  = shift;
      ck_nxt     = ps2Ck;
      d_nxt      = ps2D;
      pop        = 1'b0;

      case (state)
         IDLE: begin
            hcnt_nxt = '0;
            ck_nxt   = 1'b1;
            d_nxt    = 1'b1;
            if (!q_empty) begin
               pop        = 1'b1;
               shift_nxt  = {1'b1, ~^q_head, q_head};
               d_nxt      = 1'b0;
               bitcnt_nxt = '0;
               state_nxt  = HIGH;
            end
         end
         HIGH: begin
            if (hdone) begin
               hcnt_nxt  = '0;
               ck_nxt    = 1'b0;
               state_nxt = LOW;
            end
         end
         LOW: begin
            if (hdone) begin
               hcnt_nxt = '0;
               ck_nxt   = 1'b1;
               if (bitcnt == LAST) begin
                  d_nxt     = 1'b1;
                  gap2_nxt  = 1'b0;
                  state_nxt = GAP;
               end else begin
                  d_nxt      = shift[0];
                  shift_nxt  = {1'b1, shift[9:1]};
                  bitcnt_nxt = bitcnt + 4'd1;
                  state_nxt  = HIGH;
               end
            end
         end
         GAP: begin
            ck_nxt = 1'b1;
            d_nxt  = 1'b1;
            if (hdone) begin
               hcnt_nxt = '0;
               if (gap2) state_nxt = IDLE;
               else      gap2_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
            ck_nxt    = 1'b1;
            d_nxt     = 1'b1;
         end
      endcase
   end

   assign full_nxt = (count_nxt == CAP_C);
   assign busy_nxt = (state_nxt != IDLE) | (count_nxt != '0);

   // State and registered outputs.
   always_ff @(posedge clock or negedge power) begin
      if (!power) begin
         state  <= IDLE;
         hcnt   <= '0;
         bitcnt <= '0;
         gap2   <= 1'b0;
         shift  <= '0;
         ps2Ck  <= 1'b1;
         ps2D   <= 1'b1;
         full   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         hcnt   <= hcnt_nxt;
         bitcnt <= bitcnt_nxt;
         gap2   <= gap2_nxt;
         shift  <= shift_nxt;
         ps2Ck  <= ck_nxt;
         ps2D   <= d_nxt;
         full   <= full_nxt;
         busy   <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: directed frame table, corner-case sequences and random
// writes, checked every cycle against a timeline/queue reference model.
module tb_ps2_kbd_tx;

   localparam int CLKDIV = 4;
   localparam int AW     = 3;
   localparam int PERIOD = 24 * CLKDIV;
`ifdef PS2TX_FIFO_EN
   localparam int CAP = 1 << AW;
`else
   localparam int CAP = 1;
`endif

   logic       clock = 1'b0;
   logic       power = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       write = 1'b0;
   logic       full, busy, ps2Ck, ps2D;

   ps2_kbd_tx #(.CLKDIV(CLKDIV), .AW(AW)) dut (
      .clock(clock), .power(power), .data(data), .write(write),
      .full(full), .busy(busy), .ps2Ck(ps2Ck), .ps2D(ps2D)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Reference model state: byte queue plus position within the current frame.
   logic [7:0]  mq[$];
   logic [7:0]  pop_q[$];
   bit          m_active = 1'b0;
   int          m_ph = 0;
   logic [7:0]  m_cur = 8'h00;

   // Monitor state: frames decoded from the line.
   logic [10:0] rx_q[$];
   int          mon_nbits = 0;
   logic [10:0] mon_frm = '0;

   typedef struct {
      logic [7:0]  b;
      logic [10:0] frm;
      logic        par;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   // One clock of the model: pop when idle, frame lasts PERIOD cycles, then push.
   task automatic model_step();
      bit do_pop, acc;
      if (!power) begin
         mq.delete();
         m_active = 1'b0;
         m_ph = 0;
         return;
      end
      do_pop = !m_active && (mq.size() > 0);
      acc    = write && (mq.size() < CAP);
      if (m_active) begin
         m_ph++;
         if (m_ph == PERIOD) m_active = 1'b0;
      end
      if (do_pop) begin
         m_cur = mq.pop_front();
         pop_q.push_back(m_cur);
         m_active = 1'b1;
         m_ph = 0;
      end
      if (acc) mq.push_back(data);
   endtask

   task automatic check_cycle();
      logic eck, ed, efull, ebusy;
      logic [10:0] f;
      int b, w;
      eck = 1'b1;
      ed  = 1'b1;
      if (m_active) begin
         b = m_ph / (2 * CLKDIV);
         w = m_ph % (2 * CLKDIV);
         if (b < 11) begin
            f   = frame_of(m_cur);
            ed  = f[b];
            eck = (w < CLKDIV);
         end
      end
      efull = (mq.size() == CAP);
      ebusy = m_active || (mq.size() > 0);
      check("ps2Ck", 32'(ps2Ck), 32'(eck));
      check("ps2D",  32'(ps2D),  32'(ed));
      check("full",  32'(full),  32'(efull));
      check("busy",  32'(busy),  32'(ebusy));
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial forever begin
      @(negedge clock);
      if (power === 1'b1 && chk_en) check_cycle();
   end

   // Line monitor: sample ps2D on each ps2Ck falling edge, 11 bits per frame.
   initial begin
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clock);
         if (!power) begin
            mon_nbits = 0;
            prev = 1'b1;
         end else begin
            if (prev && !ps2Ck) begin
               mon_frm[mon_nbits] = ps2D;
               mon_nbits++;
               if (mon_nbits == 11) begin
                  rx_q.push_back(mon_frm);
                  mon_nbits = 0;
               end
            end
            prev = ps2Ck;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      data  = b;
      write = 1'b1;
      tick();
      write = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      check("wait_idle_done", 32'(n < limit), 32'd1);
   endtask

   task automatic clear_logs();
      rx_q.delete();
      pop_q.delete();
   endtask

   initial begin
      vec_t        tbl[8];
      int          n, i;
      bit          acc;
      logic [10:0] got;
      logic [7:0]  exp_b[$];

      tbl[0] = '{8'h1C, 11'h438, 1'b0};
      tbl[1] = '{8'hF0, 11'h7E0, 1'b1};
      tbl[2] = '{8'h00, 11'h600, 1'b1};
      tbl[3] = '{8'hFF, 11'h7FE, 1'b1};
      tbl[4] = '{8'h01, 11'h402, 1'b0};
      tbl[5] = '{8'h55, 11'h6AA, 1'b1};
      tbl[6] = '{8'h80, 11'h500, 1'b0};
      tbl[7] = '{8'hA5, 11'h74A, 1'b1};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_ps2Ck", 32'(ps2Ck), 32'd1);
      check("rst_ps2D",  32'(ps2D),  32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      power  = 1'b1;
      chk_en = 1'b1;
      repeat (2) tick();

      // Directed frames: latency, busy duration and decoded frame
      for (int k = 0; k < 8; k++) begin
         wait_idle(400);
         clear_logs();
         send(tbl[k].b);
         check("lat_edge1_ps2D", 32'(ps2D), 32'd1);
         tick();
         check("lat_edge2_ps2D", 32'(ps2D), 32'd0);
         n = 0;
         while (busy === 1'b1 && n < 300) begin
            tick();
            n++;
         end
         check("busy_len", 32'(n), 32'(PERIOD));
         check("frame_count", 32'(rx_q.size()), 32'd1);
         got = (rx_q.size() > 0) ? rx_q[0] : 11'h0;
         check("frame_bits", 32'(got), 32'(tbl[k].frm));
         check("frame_parity", 32'(got[9]), 32'(tbl[k].par));
      end

`ifdef PS2TX_FIFO_EN
      // Back-to-back writes: both frames sent, minimum idle gap between them
      wait_idle(400);
      clear_logs();
      data = 8'hF0; write = 1'b1; tick();
      data = 8'h00; tick();
      write = 1'b0;
      check("b2b_full", 32'(full), 32'd0);
      n = 0;
      while (rx_q.size() < 1 && n < 400) begin tick(); n++; end
      n = 0;
      while (ps2Ck === 1'b0 && n < 50) begin tick(); n++; end
      n = 0;
      while (ps2D === 1'b1 && n < 100) begin tick(); n++; end
      check("b2b_gap", 32'(n), 32'(2 * CLKDIV + 1));
      wait_idle(400);
      check("b2b_count", 32'(rx_q.size()), 32'd2);
      got = (rx_q.size() > 0) ? rx_q[0] : 11'h0;
      check("b2b_f0", 32'(got), 32'h7E0);
      got = (rx_q.size() > 1) ? rx_q[1] : 11'h0;
      check("b2b_00", 32'(got), 32'h600);

      // Overflow: 9 writes during a frame, 9th dropped
      wait_idle(400);
      clear_logs();
      exp_b.delete();
      send(8'hA0);
      exp_b.push_back(8'hA0);
      tick();
      for (int k = 0; k < 9; k++) begin
         data = 8'h30 + 8'(k);
         write = 1'b1;
         tick();
         if (k < 8) exp_b.push_back(8'h30 + 8'(k));
         if (k == 6) check("ovf_full_7", 32'(full), 32'd0);
         if (k >= 7) check("ovf_full_8", 32'(full), 32'd1);
      end
      write = 1'b0;
      wait_idle(2000);
      check("ovf_count", 32'(rx_q.size()), 32'd9);
      for (int k = 0; k < 9; k++) begin
         got = (rx_q.size() > k) ? rx_q[k] : 11'h0;
         check("ovf_frame", 32'(got), 32'(frame_of(exp_b[k])));
      end
`else
      // Holding register: second write one cycle later is dropped
      wait_idle(400);
      clear_logs();
      data = 8'h55; write = 1'b1; tick();
      check("hold_full_1", 32'(full), 32'd1);
      tick();
      write = 1'b0;
      check("hold_full_2", 32'(full), 32'd0);
      check("hold_busy_2", 32'(busy), 32'd1);
      wait_idle(400);
      check("hold_count", 32'(rx_q.size()), 32'd1);
      got = (rx_q.size() > 0) ? rx_q[0] : 11'h0;
      check("hold_frame", 32'(got), 32'h6AA);
`endif

      // Reset during the 5th data bit
      wait_idle(400);
      clear_logs();
      send(8'hB7);
      n = 0;
      while (mon_nbits < 6 && n < 200) begin tick(); n++; end
      check("rst_mid_reached", 32'(mon_nbits), 32'd6);
      #2 power = 1'b0;
      #1;
      check("rst_mid_ps2Ck", 32'(ps2Ck), 32'd1);
      check("rst_mid_ps2D",  32'(ps2D),  32'd1);
      check("rst_mid_busy",  32'(busy),  32'd0);
      check("rst_mid_full",  32'(full),  32'd0);
      repeat (3) tick();
      power = 1'b1;
      n = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (ps2D !== 1'b1 || busy !== 1'b0) n++;
      end
      check("rst_no_frame", 32'(n), 32'd0);
      check("rst_no_rx", 32'(rx_q.size()), 32'd0);

      // 20 bytes in order with flow control; writes kept high while full
      clear_logs();
      i = 0;
      n = 0;
      while (i < 20 && n < 6000) begin
         data  = 8'(i);
         write = 1'b1;
         acc   = (mq.size() < CAP);
         tick();
         n++;
         if (acc) i++;
      end
      write = 1'b0;
      check("seq20_sent", 32'(i), 32'd20);
      wait_idle(3000);
      check("seq20_count", 32'(rx_q.size()), 32'd20);
      for (int k = 0; k < 20; k++) begin
         got = (rx_q.size() > k) ? rx_q[k] : 11'h0;
         check("seq20_frame", 32'(got), 32'(frame_of(8'(k))));
      end

      // Random writes, some while full
      clear_logs();
      for (int k = 0; k < 3000; k++) begin
         write = ($urandom_range(3) == 0);
         data  = 8'($urandom);
         tick();
      end
      write = 1'b0;
      wait_idle(3000);
      check("rand_count", 32'(rx_q.size()), 32'(pop_q.size()));
      check("rand_nonempty", 32'(pop_q.size() > 10), 32'd1);
      for (int k = 0; k < pop_q.size(); k++) begin
         got = (rx_q.size() > k) ? rx_q[k] : 11'h0;
         check("rand_frame", 32'(got), 32'(frame_of(pop_q[k])));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
PS/2 device-side transmitter. It serialises queued keyboard scancode bytes onto a PS/2 clock/data pair so the glue's PS/2 keyboard receiver can be driven from a local source, such as a test injector or a scancode generator, instead of from the user_io path. It is the transmitting end of the ps2[0]/ps2[1] link that glue consumes. It is clocked from the 35.468 MHz system clock and generates the PS/2 bit clock by division.

Parameters:
CLKDIV, 1418, system clocks per PS/2 half-period (about 12.5 kHz bit rate at 35.468 MHz); legal range 2..4095.
AW, 3, FIFO address width; depth is 2**AW bytes (used only with the FIFO compiled in).

Ports:
clock  input  1  system clock, all logic on rising edge.
power  input  1  asynchronous active-low reset; low clears all state.
data   input  8  scancode byte to send.
write  input  1  one-cycle strobe; enqueue data.
full   output 1  queue cannot accept a byte.
busy   output 1  frame or gap in progress, or queue non-empty.
ps2Ck  output 1  PS/2 clock; idles high.
ps2D   output 1  PS/2 data; idles high.

Behaviour:
- Reset (power low, asynchronous): ps2Ck=1, ps2D=1, full=0, busy=0, queue emptied, FSM=IDLE, counters=0. Reset mid-frame aborts the frame and raises both lines immediately; the aborted byte is lost.
- Enqueue: write is accepted iff full=0 in that cycle. A write while full=1 is dropped, and full and queue contents are unchanged.
- A write and a pop in the same cycle are both honoured; the occupancy count is unchanged.
- full is registered and asserts on the same edge the last slot fills.
- Frame format: 11 bits, LSB-first.
  - start = 0
  - d0..d7
  - odd parity (the parity bit makes the total count of ones in d0..d7 plus parity odd)
  - stop = 1
- FSM states: IDLE, HIGH, LOW, GAP.
- IDLE: if the queue is non-empty, pop the head, load shift = {1, par, data, 0}, set ps2D = start bit, bitcnt = 0, go to HIGH. A byte written into an empty queue while in IDLE drives ps2D low on the second rising edge after the write edge (2-cycle latency).
- HIGH: ps2Ck = 1 for CLKDIV cycles, with ps2D stable from the start of the state. Then go to LOW.
- LOW: ps2Ck = 0 for CLKDIV cycles; the host samples ps2D during this state. At the end:
  - ps2Ck returns to 1.
  - If bitcnt = 10, set ps2D = 1 and go to GAP.
  - Otherwise shift, present the next bit on ps2D on the same edge, increment bitcnt, and go to HIGH.
- GAP: ps2Ck = 1 and ps2D = 1 for 2*CLKDIV cycles, then go to IDLE. A queued byte starts on the following cycle, so back-to-back frames always have at least 2*CLKDIV+1 idle-high cycles between the stop-bit clock rise and the next start bit.
- Frame period from ps2D falling (start) to GAP exit: 11*2*CLKDIV + 2*CLKDIV cycles.
- ps2Ck and ps2D are registered outputs with no combinational paths from inputs.
- busy = (FSM != IDLE) | queue non-empty.
- Queue wrap: read/write pointers are AW bits and wrap modulo 2**AW. The count is AW+1 bits: full when count = 2**AW, empty when count = 0.
- Half-period counter width: ceil(log2(CLKDIV)) bits. It reloads to 0 on each state entry.

Optional Feature:
PS2TX_FIFO_EN:
- Defined: queue is a 2**AW-entry circular FIFO as described above.
- Undefined: queue is a single holding register; AW is ignored.
  - full = holding register occupied.
  - IDLE pops it exactly as a FIFO head.
  - A write in the same cycle that IDLE empties the register is dropped, because full is still 1 in that cycle.
- Frame timing and port behaviour are otherwise identical.

Test Plan:
- CLKDIV=4. Write 0x1C in IDLE → ps2D falls 2 cycles later. Over the 11 clock-low windows ps2D reads 0,0,0,1,1,1,0,0,0,0,1 (parity 0). busy stays 1 for 96 cycles after ps2D falls, then drops.
- Write 0xF0 then 0x00 on consecutive cycles → two frames with parity bits 1 and 1 respectively. ps2Ck/ps2D are high for at least 9 cycles between frames. full is never asserted.
- FIFO build: AW=3, write 9 bytes back-to-back while a frame is in progress → full asserts after the 8th accepted byte, and the 9th is dropped. The bytes transmitted match the first 8 plus the in-flight byte, in order.
- Deassert power during the 5th data bit → ps2Ck=1, ps2D=1, busy=0, full=0 asynchronously. After release, no frame is sent until the next write.
- FIFO build: with the queue full, write and pop on the same cycle → write dropped and count drops by 1. Confirm pointer wrap by sending 20 bytes 0x00..0x13 in order.
- Build without PS2TX_FIFO_EN: write 0x55 twice 1 cycle apart while IDLE → the second write is dropped (full=1) and exactly one frame is sent.
